// File: rtl/dbus_scratch_resp_pkg.sv
// Shared types and defaults for the dual-lane scratchpad responder.
// Latency and backpressure: none here (types and helpers only).
package dbus_scratch_resp_pkg;

   localparam int HIT_LAT_DEF  = 1;
   localparam int UNC_LAT_DEF  = 4;
   localparam int DBUS_UNC_BIT = 29;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   // One lane as captured at accept; idx is the full word address, the RAM uses its low bits.
   typedef struct packed {
      logic        valid;
      logic [29:0] idx;
      logic [3:0]  strobe;
      logic [31:0] wdata;
   } resp_lane_t;

   function automatic logic [31:0] strb2mask(input logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

endpackage

// File: rtl/dbus_scratch_resp_if.sv
// Request-pair / response bundle between the memory stages (master) and the responder (slave).
// Latency and backpressure: none here; the responder paces pairs with addr_ok/data_ok.
interface dbus_scratch_resp_if;

   dbus_scratch_resp_pkg::dbus_req_t [1:0] dreq;
   dbus_scratch_resp_pkg::dbus_resp_t      dresp;

   modport master (output dreq, input dresp);
   modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_scratch_resp_scratch_ram.sv
// Byte-strobed scratchpad: two async read ports, two write ports committed on the clock edge.
// Latency: read combinational, write one edge; no backpressure; lane 0 wins same-byte writes.
module scratch_ram #(
   parameter int DEPTH_WORDS = 1024,
   localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] rd_idx0_i,
   input  logic [IDX_W-1:0] rd_idx1_i,
   output logic [31:0]      rd_dat0_o,
   output logic [31:0]      rd_dat1_o,
   input  logic             we0_i,
   input  logic [IDX_W-1:0] wr_idx0_i,
   input  logic [3:0]       wr_strb0_i,
   input  logic [31:0]      wr_dat0_i,
   input  logic             we1_i,
   input  logic [IDX_W-1:0] wr_idx1_i,
   input  logic [3:0]       wr_strb1_i,
   input  logic [31:0]      wr_dat1_i
);

   logic [31:0] mem [DEPTH_WORDS];

   assign rd_dat0_o = mem[rd_idx0_i];
   assign rd_dat1_o = mem[rd_idx1_i];

   // Lane 0 is written last so its bytes override lane 1 on overlap.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we1_i && wr_strb1_i[b]) mem[wr_idx1_i][8*b +: 8] <= wr_dat1_i[8*b +: 8];
         if (we0_i && wr_strb0_i[b]) mem[wr_idx0_i][8*b +: 8] <= wr_dat0_i[8*b +: 8];
      end
   end

endmodule

// File: rtl/dbus_scratch_resp.sv
// Dual-lane dbus responder over a scratchpad; data_ok HIT_LAT/UNC_LAT cycles after accept, one pair in flight.
// addr_ok only in IDLE; optional DBUS_RESP_FWD_EN forwards lane 1 store bytes to a lane 0 load of the same word.
module dbus_scratch_resp
   import dbus_scratch_resp_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int HIT_LAT     = HIT_LAT_DEF,
   parameter int UNC_LAT     = UNC_LAT_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   dbus_scratch_resp_if.slave dbus
);

   localparam int IDX_W  = $clog2(DEPTH_WORDS);
   localparam int MAX_L  = (UNC_LAT > HIT_LAT) ? UNC_LAT : HIT_LAT;
   localparam int CNT_W  = (MAX_L > 1) ? $clog2(MAX_L) : 1;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             data_ok_q;
   resp_lane_t       lane_q [2];
   logic [63:0]      rdata_q;

   logic [1:0]       v;
   logic             accept;
   logic             unc;
   logic [CNT_W-1:0] lat_m1;
   logic [IDX_W-1:0] ridx0, ridx1;
   logic [31:0]      rd0, rd1, ld0;
   logic [63:0]      rdata_d;
   logic             we0, we1;
   dbus_resp_t       resp;

   assign v[0]   = dbus.dreq[0].valid;
   assign v[1]   = dbus.dreq[1].valid;
   assign accept = resetn && (state_q == S_IDLE) && (|v);
   assign unc    = (v[0] && dbus.dreq[0].addr[DBUS_UNC_BIT]) ||
                   (v[1] && dbus.dreq[1].addr[DBUS_UNC_BIT]);
   assign lat_m1 = unc ? CNT_W'(UNC_LAT - 1) : CNT_W'(HIT_LAT - 1);
   assign ridx0  = dbus.dreq[0].addr[IDX_W+1:2];
   assign ridx1  = dbus.dreq[1].addr[IDX_W+1:2];

`ifdef DBUS_RESP_FWD_EN
   logic        fwd_hit;
   logic [31:0] fwd_mask;
   assign fwd_hit  = v[1] && (dbus.dreq[1].strobe != 4'h0) && (ridx0 == ridx1);
   assign fwd_mask = strb2mask(dbus.dreq[1].strobe);
   assign ld0      = fwd_hit ? ((rd0 & ~fwd_mask) | (dbus.dreq[1].data & fwd_mask)) : rd0;
`else
   assign ld0      = rd0;
`endif

   assign rdata_d = {v[0] ? ld0 : 32'h0, v[1] ? rd1 : 32'h0};

   // Writes land on the data_ok edge; a reset in that same cycle abandons them.
   assign we0 = data_ok_q && resetn && lane_q[0].valid && (lane_q[0].strobe != 4'h0);
   assign we1 = data_ok_q && resetn && lane_q[1].valid && (lane_q[1].strobe != 4'h0);

   scratch_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
      .clk        (clk),
      .rd_idx0_i  (ridx0),
      .rd_idx1_i  (ridx1),
      .rd_dat0_o  (rd0),
      .rd_dat1_o  (rd1),
      .we0_i      (we0),
      .wr_idx0_i  (lane_q[0].idx[IDX_W-1:0]),
      .wr_strb0_i (lane_q[0].strobe),
      .wr_dat0_i  (lane_q[0].wdata),
      .we1_i      (we1),
      .wr_idx1_i  (lane_q[1].idx[IDX_W-1:0]),
      .wr_strb1_i (lane_q[1].strobe),
      .wr_dat1_i  (lane_q[1].wdata)
   );

   // data_ok_q mirrors (state_q == S_WAIT && cnt_q == 0).
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         data_ok_q <= 1'b0;
         lane_q[0] <= '0;
         lane_q[1] <= '0;
         rdata_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (|v) begin
                  for (int i = 0; i < 2; i++) begin
                     lane_q[i].valid  <= v[i];
                     lane_q[i].idx    <= dbus.dreq[i].addr[31:2];
                     lane_q[i].strobe <= dbus.dreq[i].strobe;
                     lane_q[i].wdata  <= dbus.dreq[i].data;
                  end
                  rdata_q   <= rdata_d;
                  cnt_q     <= lat_m1;
                  data_ok_q <= (lat_m1 == '0);
                  state_q   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (data_ok_q) begin
                  data_ok_q <= 1'b0;
                  state_q   <= S_IDLE;
               end else begin
                  cnt_q     <= cnt_q - 1'b1;
                  data_ok_q <= (cnt_q == CNT_W'(1));
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      resp         = '0;
      resp.addr_ok = accept;
      resp.data_ok = data_ok_q && resetn;
      resp.data    = (data_ok_q && resetn) ? rdata_q : 64'h0;
   end

   assign dbus.dresp = resp;

endmodule

// File: tb/tb_dbus_scratch_resp.sv
// Directed bench for dbus_scratch_resp with default depth and latencies.
module tb_dbus_scratch_resp;
   import dbus_scratch_resp_pkg::*;

   logic clk;
   logic resetn;
   int   checks;
   int   errors;
   logic [63:0] rd;

   dbus_scratch_resp_if bus ();

   dbus_scratch_resp dut (
      .clk    (clk),
      .resetn (resetn),
      .dbus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic v1, input logic [31:0] a1, input logic [3:0] s1,
                          input logic [31:0] d1, input logic v0, input logic [31:0] a0,
                          input logic [3:0] s0, input logic [31:0] d0);
      bus.dreq[1] = '{valid: v1, addr: a1, strobe: s1, data: d1};
      bus.dreq[0] = '{valid: v0, addr: a0, strobe: s0, data: d0};
   endtask

   // Entered one time unit after a rising edge with the DUT in IDLE; leaves at the same phase, IDLE again.
   task automatic do_pair(input string tag, input logic v1, input logic [31:0] a1,
                          input logic [3:0] s1, input logic [31:0] d1, input logic v0,
                          input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] d0,
                          input int lat, output logic [63:0] data);
      set_req(v1, a1, s1, d1, v0, a0, s0, d0);
      #1;
      chk({tag, "_addr_ok"}, 64'(bus.dresp.addr_ok), 64'h1);
      @(posedge clk); #1;
      // Scramble the request after accept: it must be ignored.
      set_req(1'b0, 32'hFFFF_FFFC, 4'hF, 32'h5A5A_5A5A, 1'b0, 32'hFFFF_FFFC, 4'hF, 32'hA5A5_A5A5);
      for (int k = 1; k < lat; k++) begin
         chk({tag, "_early_data_ok"}, 64'(bus.dresp.data_ok), 64'h0);
         chk({tag, "_wait_addr_ok"}, 64'(bus.dresp.addr_ok), 64'h0);
         @(posedge clk); #1;
      end
      chk({tag, "_data_ok"}, 64'(bus.dresp.data_ok), 64'h1);
      chk({tag, "_resp_addr_ok"}, 64'(bus.dresp.addr_ok), 64'h0);
      data = bus.dresp.data;
      @(posedge clk); #1;
      chk({tag, "_data_ok_drop"}, 64'(bus.dresp.data_ok), 64'h0);
      chk({tag, "_data_zero"}, bus.dresp.data, 64'h0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      resetn = 1'b0;
      set_req(1'b1, 32'h10, 4'hF, 32'h1234_5678, 1'b0, 32'h0, 4'h0, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      chk("rst_addr_ok", 64'(bus.dresp.addr_ok), 64'h0);
      chk("rst_data_ok", 64'(bus.dresp.data_ok), 64'h0);
      chk("rst_data", bus.dresp.data, 64'h0);

      resetn = 1'b1;
      do_pair("st_full", 1'b1, 32'h10, 4'hF, 32'h1234_5678, 1'b0, 32'h0, 4'h0, 32'h0, 1, rd);

      do_pair("ld_full", 1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1, rd);
      chk("ld_full_data", rd, 64'h0000_0000_1234_5678);

      do_pair("st_byte", 1'b1, 32'h10, 4'b0010, 32'h0000_AB00, 1'b0, 32'h0, 4'h0, 32'h0, 1, rd);
      do_pair("ld_byte", 1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1, rd);
      chk("ld_byte_data", rd, 64'h0000_0000_1234_AB78);

      // Seed 0x20 and 0x40 with known words, both lanes storing in one pair.
      do_pair("seed", 1'b1, 32'h40, 4'hF, 32'h0, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D, 1, rd);

      // Same-word stores: lane 0 bytes win on overlap.
      do_pair("st_conf", 1'b1, 32'h80, 4'hF, 32'h1111_1111, 1'b1, 32'h80, 4'b0011, 32'h2222_2222, 1, rd);
      do_pair("ld_conf", 1'b1, 32'h80, 4'h0, 32'h0, 1'b1, 32'h10, 4'h0, 32'h0, 1, rd);
      chk("ld_conf_data", rd, 64'h1234_AB78_1111_2222);

      do_pair("unc", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'hA000_0020, 4'h0, 32'h0, 4, rd);
      chk("unc_data", rd, 64'hCAFE_F00D_0000_0000);

      do_pair("fwd", 1'b1, 32'h40, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h40, 4'h0, 32'h0, 1, rd);
`ifdef DBUS_RESP_FWD_EN
      chk("fwd_data", rd, 64'hDEAD_BEEF_0000_0000);
`else
      chk("fwd_data", rd, 64'h0000_0000_0000_0000);
`endif
      do_pair("fwd_after", 1'b1, 32'h40, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1, rd);
      chk("fwd_after_data", rd, 64'h0000_0000_DEAD_BEEF);

      // Reset during WAIT of an uncached store to 0x20.
      set_req(1'b1, 32'h2000_0020, 4'hF, 32'h5555_5555, 1'b0, 32'h0, 4'h0, 32'h0);
      #1;
      chk("rstw_addr_ok", 64'(bus.dresp.addr_ok), 64'h1);
      @(posedge clk); #1;
      set_req(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
      chk("rstw_t1_data_ok", 64'(bus.dresp.data_ok), 64'h0);
      @(posedge clk); #1;
      resetn = 1'b0;
      #1;
      chk("rstw_t2_data_ok", 64'(bus.dresp.data_ok), 64'h0);
      @(posedge clk); #1;
      chk("rstw_t3_data_ok", 64'(bus.dresp.data_ok), 64'h0);
      @(posedge clk); #1;
      resetn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         chk("rstw_no_data_ok", 64'(bus.dresp.data_ok), 64'h0);
         @(posedge clk); #1;
      end
      do_pair("rstw_ld", 1'b1, 32'h20, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1, rd);
      chk("rstw_ld_data", rd, 64'h0000_0000_CAFE_F00D);

      do_pair("wrap_st", 1'b1, 32'h1000, 4'hF, 32'h7777_7777, 1'b0, 32'h0, 4'h0, 32'h0, 1, rd);
      do_pair("wrap_ld", 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 1, rd);
      chk("wrap_ld_data", rd, 64'h7777_7777_0000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
